display_arbiter: RTL

Shares the 4-digit multiplexed 7-segment display between two requesters: the live note view (key currently held) and a transient message source (e.g. octave/volume change banner). Messages are accepted with a req/ack handshake, buffered, and shown for a fixed number of scan ticks before the display returns to the note view. The block owns digit scanning and drives the board `an`/`seg` pins directly, in place of a free-running per-source scanner.

---
 rtl/display_pkg.sv | 7 +
 rtl/scan_prescaler.sv | 17 +
 rtl/display_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared types and segment constants for the display arbiter
package display_pkg;
    typedef logic [3:0][7:0] seg_frame_t;
    typedef enum logic [1:0] {IDLE, NOTE, MSG} disp_arb_state_t;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: divides clk down to a one-cycle digit-step tick every SCAN_DIV cycles
module scan_prescaler #(
    parameter int SCAN_DIV = 262144
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int W = $clog2(SCAN_DIV);
    logic [W-1:0] r_cnt;
    assign tick = (r_cnt == W'(SCAN_DIV - 1));
    // count 0..SCAN_DIV-1 and wrap on the tick cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: shares the 4-digit 7-segment display between note view and buffered messages; DISPLAY_ARB_RETRIGGER_EN lets a new message replace one on screen
module display_arbiter
    import display_pkg::*;
#(
    parameter int SCAN_DIV   = 262144,
    parameter int HOLD_TICKS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        note_valid,
    input  logic [31:0] note_seg,
    input  logic        msg_req,
    input  logic [31:0] msg_seg,
    output logic        msg_ack,
    output logic        busy,
    output logic [3:0]  an,
    output logic [7:0]  seg
);
    localparam int HW = $clog2(HOLD_TICKS + 1);
`ifdef DISPLAY_ARB_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic             w_tick;
    disp_arb_state_t  r_state, w_state_nxt;
    logic [HW-1:0]    r_hold, w_hold_nxt;
    seg_frame_t       r_buf, w_buf_nxt, w_frame;
    logic             r_run, w_run;
    logic [1:0]       r_digit, w_digit_nxt;
    logic             r_ack, r_busy;
    logic [3:0]       r_an;
    logic [7:0]       r_seg;
    logic             w_accept, w_expire;

    scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign msg_ack = r_ack;
    assign busy    = r_busy;
    assign an      = r_an;
    assign seg     = r_seg;

    // next state, hold counter, buffer and scan position; the ack cycle is excluded so a still-high request is not taken twice
    always_comb begin
        w_accept    = msg_req && !r_ack && (r_state != MSG || RETRIG);
        w_expire    = (r_state == MSG) && w_tick && (r_hold == HW'(HOLD_TICKS - 1));
        w_state_nxt = note_valid ? NOTE : IDLE;
        w_hold_nxt  = r_hold;
        w_buf_nxt   = r_buf;
        if (w_accept) begin
            w_state_nxt = MSG;
            w_hold_nxt  = '0;
            w_buf_nxt   = msg_seg;
        end else if (r_state == MSG) begin
            w_state_nxt = w_expire ? (note_valid ? NOTE : IDLE) : MSG;
            w_hold_nxt  = w_expire ? '0 : (w_tick ? r_hold + 1'b1 : r_hold);
        end
        w_frame     = (r_state == MSG)  ? r_buf :
                      (r_state == NOTE) ? seg_frame_t'(note_seg) : {4{SEG_DASH}};
        w_run       = r_run | w_tick;
        w_digit_nxt = (w_tick && r_run) ? r_digit + 2'd1 : r_digit;
    end

    // state register plus registered outputs; an and seg are loaded from the same digit so they always move together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_buf   <= {4{SEG_BLANK}};
            r_run   <= 1'b0;
            r_digit <= 2'd0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_an    <= 4'hF;
            r_seg   <= SEG_BLANK;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_buf   <= w_buf_nxt;
            r_run   <= w_run;
            r_digit <= w_digit_nxt;
            r_ack   <= w_accept;
            r_busy  <= (w_state_nxt == MSG);
            r_an    <= w_run ? ~(4'b0001 << w_digit_nxt) : 4'hF;
            r_seg   <= w_run ? w_frame[w_digit_nxt] : SEG_BLANK;
        end
    end
endmodule
